// File: rtl/rcon_seq.sv
// rcon_seq: sequential AES round-constant generator.
// Emits {rc,24'h0} one word per accepted handshake, forward (rc_1..rc_N)
// or reverse (rc_N..rc_1). All outputs come straight from registers.
module rcon_seq #(
  parameter int NUM_RCON = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        mode,
  input  logic        clear,
  input  logic        advance,
  output logic        ready,
  output logic        valid,
  output logic [31:0] word,
  output logic [3:0]  index,
  output logic        last,
  output logic        done
);

  // GF(2^8) multiply by x, reduction polynomial 0x11b
  function automatic logic [7:0] xtime(input logic [7:0] v);
    return {v[6:0], 1'b0} ^ (v[7] ? 8'h1b : 8'h00);
  endfunction

  // GF(2^8) divide by x; the low bit set means 0x1b was folded in
  function automatic logic [7:0] inv_xtime(input logic [7:0] v);
    return v[0] ? (({1'b0, v[7:1]} ^ 8'h0d) | 8'h80) : {1'b0, v[7:1]};
  endfunction

  // rc_N, the first word of a reverse sequence
  function automatic logic [7:0] calc_rc_last(input int n);
    logic [7:0] r;
    r = 8'h01;
    for (int i = 1; i < n; i++) r = xtime(r);
    return r;
  endfunction

  localparam logic [7:0] RC_LAST = calc_rc_last(NUM_RCON);
  localparam logic [3:0] NR      = 4'(NUM_RCON);
  localparam logic [3:0] NR_M1   = 4'(NUM_RCON - 1);

  // the constant table only reaches 14 entries before rc would wrap
  generate
    if (NUM_RCON < 1 || NUM_RCON > 14) begin : g_bad_num_rcon
      $error("rcon_seq: NUM_RCON must be in 1..14");
    end
  endgenerate

  typedef enum logic {IDLE, RUN} state_t;

  state_t     state;
  logic [7:0] rc;
  logic       rev;

  // word is a pure wiring of the rc register, so it stays registered
  assign word = {rc, 24'h000000};

  // sequencer: start loads the first constant, advance steps, clear aborts
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ready <= 1'b1;
      valid <= 1'b0;
      rc    <= 8'h00;
      index <= 4'd0;
      last  <= 1'b0;
      done  <= 1'b0;
      rev   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state <= RUN;
            ready <= 1'b0;
            valid <= 1'b1;
            rev   <= mode;
            last  <= (NR == 4'd1);
            if (mode) begin
              rc    <= RC_LAST;
              index <= NR;
            end else begin
              rc    <= 8'h01;
              index <= 4'd1;
            end
          end
        end
        RUN: begin
          if (clear) begin
            state <= IDLE;
            ready <= 1'b1;
            valid <= 1'b0;
            rc    <= 8'h00;
            index <= 4'd0;
            last  <= 1'b0;
          end else if (advance) begin
            if (last) begin
              state <= IDLE;
              ready <= 1'b1;
              valid <= 1'b0;
              rc    <= 8'h00;
              index <= 4'd0;
              last  <= 1'b0;
              done  <= 1'b1;
            end else if (rev) begin
              rc    <= inv_xtime(rc);
              index <= index - 4'd1;
              last  <= (index == 4'd2);
            end else begin
              rc    <= xtime(rc);
              index <= index + 4'd1;
              last  <= (index == NR_M1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rcon_seq.sv
// tb_rcon_seq: directed bench for rcon_seq across AES-128/256 lengths and
// the 14- and 1-entry extremes. Each instance has its own start line.
module tb_rcon_seq;

  logic clk = 1'b0;
  logic rst_n, mode, clear, advance;
  logic st10, st7, st14, st1;

  logic r10, v10, l10, d10; logic [31:0] w10; logic [3:0] i10;
  logic r7,  v7,  l7,  d7;  logic [31:0] w7;  logic [3:0] i7;
  logic r14, v14, l14, d14; logic [31:0] w14; logic [3:0] i14;
  logic r1,  v1,  l1,  d1;  logic [31:0] w1;  logic [3:0] i1;

  int checks = 0;
  int errors = 0;

  logic [7:0] rct [14] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
                           8'h80, 8'h1b, 8'h36, 8'h6c, 8'hd8, 8'hab, 8'h4d};

  always #5 clk = ~clk;

  rcon_seq #(.NUM_RCON(10)) u10 (.clk(clk), .rst_n(rst_n), .start(st10), .mode(mode),
    .clear(clear), .advance(advance), .ready(r10), .valid(v10), .word(w10),
    .index(i10), .last(l10), .done(d10));
  rcon_seq #(.NUM_RCON(7)) u7 (.clk(clk), .rst_n(rst_n), .start(st7), .mode(mode),
    .clear(clear), .advance(advance), .ready(r7), .valid(v7), .word(w7),
    .index(i7), .last(l7), .done(d7));
  rcon_seq #(.NUM_RCON(14)) u14 (.clk(clk), .rst_n(rst_n), .start(st14), .mode(mode),
    .clear(clear), .advance(advance), .ready(r14), .valid(v14), .word(w14),
    .index(i14), .last(l14), .done(d14));
  rcon_seq #(.NUM_RCON(1)) u1 (.clk(clk), .rst_n(rst_n), .start(st1), .mode(mode),
    .clear(clear), .advance(advance), .ready(r1), .valid(v1), .word(w1),
    .index(i1), .last(l1), .done(d1));

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; #12;
    checks++; if (r10 !== 1'b1) begin errors++; $display("FAIL rst_ready got %b exp 1", r10); end
    checks++; if (v10 !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", v10); end
    checks++; if (w10 !== 32'h0) begin errors++; $display("FAIL rst_word got %h exp 0", w10); end
    checks++; if (i10 !== 4'd0) begin errors++; $display("FAIL rst_index got %0d exp 0", i10); end
    checks++; if (l10 !== 1'b0 || d10 !== 1'b0) begin errors++; $display("FAIL rst_last_done got %b%b exp 00", l10, d10); end
    tick(); rst_n = 1'b1; tick();
    // mid-run asynchronous reset at index 5
    mode = 1'b0; st10 = 1'b1; tick(); st10 = 1'b0;
    advance = 1'b1; repeat (4) tick(); advance = 1'b0;
    checks++; if (i10 !== 4'd5 || w10 !== 32'h10000000) begin errors++; $display("FAIL pre_rst got idx %0d word %h exp 5 10000000", i10, w10); end
    #2 rst_n = 1'b0; #1;
    checks++; if (v10 !== 1'b0 || r10 !== 1'b1 || w10 !== 32'h0 || i10 !== 4'd0 || l10 !== 1'b0 || d10 !== 1'b0)
      begin errors++; $display("FAIL async_rst got r%b v%b w%h i%0d l%b d%b exp r1 v0 w0 i0 l0 d0", r10, v10, w10, i10, l10, d10); end
    tick(); rst_n = 1'b1; tick();
    checks++; if (r10 !== 1'b1 || v10 !== 1'b0) begin errors++; $display("FAIL post_rst got r%b v%b exp r1 v0", r10, v10); end
  endtask

  task automatic test_forward();
    mode = 1'b0; advance = 1'b1; st10 = 1'b1; tick(); st10 = 1'b0;
    for (int k = 0; k < 10; k++) begin
      checks++; if (w10 !== {rct[k], 24'h0} || i10 !== 4'(k + 1) || l10 !== (k == 9) || d10 !== 1'b0 || v10 !== 1'b1)
        begin errors++; $display("FAIL fwd_%0d got w%h i%0d l%b d%b v%b exp w%h i%0d l%b", k, w10, i10, l10, d10, v10, {rct[k], 24'h0}, k + 1, k == 9); end
      tick();
    end
    checks++; if (d10 !== 1'b1 || r10 !== 1'b1 || v10 !== 1'b0 || w10 !== 32'h0)
      begin errors++; $display("FAIL fwd_done got d%b r%b v%b w%h exp d1 r1 v0 w0", d10, r10, v10, w10); end
    advance = 1'b0; tick();
    checks++; if (d10 !== 1'b0) begin errors++; $display("FAIL fwd_done_pulse got %b exp 0", d10); end
  endtask

  task automatic test_reverse();
    mode = 1'b1; advance = 1'b1; st7 = 1'b1; tick(); st7 = 1'b0; mode = 1'b0;
    for (int k = 0; k < 7; k++) begin
      checks++; if (w7 !== {rct[6 - k], 24'h0} || i7 !== 4'(7 - k) || l7 !== (k == 6) || v7 !== 1'b1)
        begin errors++; $display("FAIL rev_%0d got w%h i%0d l%b v%b exp w%h i%0d l%b", k, w7, i7, l7, v7, {rct[6 - k], 24'h0}, 7 - k, k == 6); end
      tick();
    end
    checks++; if (d7 !== 1'b1 || r7 !== 1'b1 || v7 !== 1'b0) begin errors++; $display("FAIL rev_done got d%b r%b v%b exp d1 r1 v0", d7, r7, v7); end
    advance = 1'b0; tick();
  endtask

  task automatic test_backpressure();
    logic [31:0] expw [5] = '{32'h01000000, 32'h02000000, 32'h02000000, 32'h02000000, 32'h04000000};
    logic        adv  [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    mode = 1'b0; st10 = 1'b1; tick(); st10 = 1'b0;
    for (int k = 0; k < 5; k++) begin
      checks++; if (w10 !== expw[k] || v10 !== 1'b1) begin errors++; $display("FAIL bp_%0d got w%h v%b exp %h", k, w10, v10, expw[k]); end
      advance = adv[k]; tick();
    end
    checks++; if (i10 !== 4'd3) begin errors++; $display("FAIL bp_index got %0d exp 3", i10); end
    clear = 1'b1; tick(); clear = 1'b0;
  endtask

  task automatic test_abort();
    mode = 1'b0; st10 = 1'b1; tick(); st10 = 1'b0;
    advance = 1'b1; repeat (3) tick();
    checks++; if (i10 !== 4'd4) begin errors++; $display("FAIL abort_pre got %0d exp 4", i10); end
    clear = 1'b1; tick(); clear = 1'b0; advance = 1'b0;
    checks++; if (v10 !== 1'b0 || r10 !== 1'b1 || d10 !== 1'b0 || w10 !== 32'h0 || i10 !== 4'd0 || l10 !== 1'b0)
      begin errors++; $display("FAIL abort got v%b r%b d%b w%h i%0d l%b exp v0 r1 d0 w0 i0 l0", v10, r10, d10, w10, i10, l10); end
    st10 = 1'b1; tick(); st10 = 1'b0;
    checks++; if (w10 !== 32'h01000000 || i10 !== 4'd1) begin errors++; $display("FAIL abort_restart got w%h i%0d exp 01000000 1", w10, i10); end
    clear = 1'b1; tick(); clear = 1'b0;
  endtask

  task automatic test_ignored();
    // IDLE ignores advance and clear
    advance = 1'b1; clear = 1'b1; tick(); advance = 1'b0; clear = 1'b0;
    checks++; if (v10 !== 1'b0 || r10 !== 1'b1) begin errors++; $display("FAIL idle_ign got v%b r%b exp v0 r1", v10, r10); end
    mode = 1'b0; st10 = 1'b1; tick();
    // start and mode flip while running: sequence keeps going forward
    mode = 1'b1; advance = 1'b1; tick(); tick();
    st10 = 1'b0; mode = 1'b0; advance = 1'b0;
    checks++; if (w10 !== 32'h04000000 || i10 !== 4'd3) begin errors++; $display("FAIL run_ign got w%h i%0d exp 04000000 3", w10, i10); end
    clear = 1'b1; tick(); clear = 1'b0;
  endtask

  task automatic test_back_to_back();
    mode = 1'b0; advance = 1'b1; st10 = 1'b1; tick(); st10 = 1'b0;
    repeat (10) tick();
    checks++; if (d10 !== 1'b1 || v10 !== 1'b0) begin errors++; $display("FAIL b2b_gap got d%b v%b exp d1 v0", d10, v10); end
    st10 = 1'b1; tick(); st10 = 1'b0; advance = 1'b0;
    checks++; if (v10 !== 1'b1 || w10 !== 32'h01000000 || i10 !== 4'd1 || d10 !== 1'b0)
      begin errors++; $display("FAIL b2b_restart got v%b w%h i%0d d%b exp v1 01000000 1 d0", v10, w10, i10, d10); end
    clear = 1'b1; tick(); clear = 1'b0;
  endtask

  task automatic test_extremes();
    mode = 1'b0; advance = 1'b1; st14 = 1'b1; tick(); st14 = 1'b0;
    for (int k = 0; k < 14; k++) begin
      checks++; if (w14 !== {rct[k], 24'h0} || i14 !== 4'(k + 1) || l14 !== (k == 13))
        begin errors++; $display("FAIL n14_%0d got w%h i%0d l%b exp w%h i%0d l%b", k, w14, i14, l14, {rct[k], 24'h0}, k + 1, k == 13); end
      tick();
    end
    checks++; if (d14 !== 1'b1) begin errors++; $display("FAIL n14_done got %b exp 1", d14); end
    advance = 1'b0; tick();
    for (int m = 0; m < 2; m++) begin
      mode = m[0]; st1 = 1'b1; tick(); st1 = 1'b0;
      checks++; if (w1 !== 32'h01000000 || l1 !== 1'b1 || i1 !== 4'd1 || v1 !== 1'b1)
        begin errors++; $display("FAIL n1_m%0d got w%h l%b i%0d v%b exp 01000000 l1 i1 v1", m, w1, l1, i1, v1); end
      advance = 1'b1; tick(); advance = 1'b0;
      checks++; if (d1 !== 1'b1 || r1 !== 1'b1 || v1 !== 1'b0) begin errors++; $display("FAIL n1_done_m%0d got d%b r%b v%b exp d1 r1 v0", m, d1, r1, v1); end
      tick();
    end
  endtask

  initial begin
    rst_n = 1'b0; mode = 1'b0; clear = 1'b0; advance = 1'b0;
    st10 = 1'b0; st7 = 1'b0; st14 = 1'b0; st1 = 1'b0;
    test_reset();
    test_forward();
    test_reverse();
    test_backpressure();
    test_abort();
    test_ignored();
    test_back_to_back();
    test_extremes();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rcon_seq.md
# rcon_seq

Sequential AES round-constant generator, the parametrised successor to the combinational `rcon` lookup. It emits the round-constant words `{rc, 24'h0}` one per accepted handshake, in forward order for encryption key expansion or reverse order for decryption. The sequence length is set by a parameter to cover AES-128, AES-192 and AES-256. It sits between the key-schedule controller, which requests words, and the key-expansion datapath, which consumes them.

## Interface
- `NUM_RCON`, default 10: number of constants in one sequence, legal range 1..14.
  - Use 10 for AES-128, 8 for AES-192, 7 for AES-256.
  - Out-of-range values are an elaboration error (`$error` in a generate check).
- `clk`, input, 1: single clock; all state changes on the rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `start`, input, 1: begin a sequence; sampled only while `ready`=1.
- `mode`, input, 1: 0 = forward (rc_1..rc_N), 1 = reverse (rc_N..rc_1); sampled with `start`.
- `clear`, input, 1: synchronous abort of a running sequence.
- `advance`, input, 1: consumer accepts the current word; effective only while `valid`=1.
- `ready`, output, 1: idle; a new `start` will be accepted.
- `valid`, output, 1: `word`/`index`/`last` hold a live constant.
- `word`, output, 32: `{rc, 24'h000000}`.
- `index`, output, 4: 1-based round number of the current rc.
- `last`, output, 1: current word is the final word of the sequence.
- `done`, output, 1: one-cycle pulse after the final word is accepted.

## Operation
- **FSM states:** IDLE, RUN. On reset: IDLE, `ready`=1, `valid`=0, `word`=0, `index`=0, `last`=0, `done`=0, `rc`=8'h00.
- **IDLE, `start`=1:** go to RUN.
  - Forward: `rc`=8'h01, `index`=1.
  - Reverse: `rc`=RC_LAST, `index`=NUM_RCON. RC_LAST is computed at elaboration by a constant function that applies xtime NUM_RCON-1 times to 8'h01.
  - `valid`=1, `ready`=0.
- **IDLE, other inputs:** `advance` and `clear` are ignored.
- **RUN, `valid` && `advance`, not `last`:** step to the next constant.
  - Forward: `rc` <= xtime(rc) = `{rc[6:0],1'b0}` ^ (rc[7] ? 8'h1b : 8'h00); `index`+1.
  - Reverse: `rc` <= inv_xtime(rc) = rc[0] ? `({1'b0,rc[7:1]} ^ 8'h0d) | 8'h80` : `{1'b0,rc[7:1]}`; `index`-1.
- **RUN, `valid` && `advance` && `last`:** go to IDLE; `valid`=0, `ready`=1, `done`=1 for one cycle, `word` zeroed.
- **RUN, `valid` && !`advance`:** `word`, `index` and `last` hold stable indefinitely.
- **`last`:** equals (`index`==NUM_RCON) in forward mode and (`index`==1) in reverse mode. It is registered and updated together with `index`.
- **`clear` in RUN:** go to IDLE next cycle; `valid`=0, `ready`=1, `word`/`index`/`last` zeroed, no `done` pulse. `clear` has priority over `advance`.
- **`start` in RUN:** ignored. `mode` changes in RUN are ignored.
- **NUM_RCON=1:** the first word is already `last`. Sequence is 8'h01 in both modes.
- **Expected rc values:** 01 02 04 08 10 20 40 80 1b 36 6c d8 ab 4d. No wrap is possible within the legal range.

## Timing
- Start latency: `start` sampled at edge t gives `valid`=1 with the first word after edge t.
- Throughput: one word per cycle with `advance` held high. A full sequence takes NUM_RCON cycles in RUN.
- `done` is high during the cycle after the final acceptance edge, coincident with `ready` returning to 1.
- A `start` in that same cycle is accepted, so back-to-back sequences have one idle cycle between them.
- Asserting `rst_n`=0 at any time, including mid-sequence, immediately forces all outputs to their reset values without waiting for `clk`. The block leaves reset in IDLE.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
- **Reset:** `rst_n` low mid-RUN (forward, `index`=5) -> outputs go to reset values asynchronously; after release `ready`=1, `valid`=0.
- **Forward, NUM_RCON=10:** `start`, `mode`=0, `advance` held 1 -> words 01000000, 02000000, … 80000000, 1b000000, 36000000 on consecutive cycles; `index` 1..10; `last` only with 36000000; `done` pulse next cycle.
- **Reverse, NUM_RCON=7:** `start`, `mode`=1 -> 40000000 down to 01000000; `index` 7..1; `last` with 01000000.
- **Backpressure:** forward run with `advance` toggled 1,0,0,1 -> `word` 02000000 holds for 3 cycles; no value skipped or repeated.
- **Abort:** forward run, `clear` together with `advance` at `index`=4 -> next cycle `valid`=0, `ready`=1, `done`=0. A following `start` restarts at 01000000.
- **Ignored inputs and extremes:**
  - `start` during RUN has no effect.
  - NUM_RCON=14 forward ends at 4d000000.
  - NUM_RCON=1 gives the single word 01000000 with `last`=1.
